// File: rtl/dbg_trace_capture_pkg.sv
// Shared types and constants for the trace capture block: FSM states, dump header
// bytes and a constant-evaluable ceil(log2) helper.
package dbg_trace_capture_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPrefill,
    StWaitTrig,
    StPost,
    StDump
  } state_e;

  localparam logic [7:0] HDR0 = 8'hA5;
  localparam logic [7:0] HDR1 = 8'h5A;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dbg_trace_capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// The read register only updates on re, so a fetched sample stays put while it is serialised.
module dbg_trace_capture_ram
  import dbg_trace_capture_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 256
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      re,
  input  logic [clog2(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]          rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dbg_trace_capture.sv
// Logic-analyser style capture: circular pre-trigger history, then a frozen buffer streamed
// out as a header plus LSB-first sample bytes over a valid/ready byte link.
module dbg_trace_capture
  import dbg_trace_capture_pkg::*;
#(
  parameter int unsigned PROBE_W  = 62,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned PRE_TRIG = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PROBE_W-1:0] probe_in,
  input  logic               trig_in,
  input  logic               arm,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               done
);

  localparam int unsigned BYTES = (PROBE_W + 7) / 8;
  localparam int unsigned W     = BYTES * 8;
  localparam int unsigned AW    = clog2(DEPTH);
  localparam int unsigned TOTAL = DEPTH * BYTES + 2;
  localparam int unsigned CW    = clog2(TOTAL + 1);
  localparam int unsigned BSW   = (BYTES > 1) ? clog2(BYTES) : 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   trig_addr_q, trig_addr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BSW-1:0]  bsel_q, bsel_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            done_q, done_d;

  logic            we, re;
  logic [W-1:0]    wr_data, rd_data;
  logic [7:0]      smp_byte;

  assign wr_data = W'(probe_in);

  dbg_trace_capture_ram #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .re      (re),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  always_comb begin
    smp_byte = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (bsel_q == BSW'(i)) smp_byte = rd_data[i*8 +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    trig_addr_d = trig_addr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    bsel_d      = bsel_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    done_d      = 1'b0;
    we          = 1'b0;
    re          = 1'b0;
    case (state_q)
      StIdle: begin
        if (arm) begin
          state_d  = StPrefill;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end
      end
      StPrefill: begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(PRE_TRIG - 1)) begin
          state_d = StWaitTrig;
          cnt_d   = '0;
        end
      end
      StWaitTrig: begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (trig_in) begin
          trig_addr_d = wr_ptr_q;
          cnt_d       = '0;
          state_d     = StPost;
        end
      end
      StPost: begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(DEPTH - PRE_TRIG - 2)) begin
          state_d  = StDump;
          cnt_d    = '0;
          bsel_d   = '0;
          rd_ptr_d = trig_addr_q - AW'(PRE_TRIG);
        end
      end
      StDump: begin
        // cnt counts bytes loaded into the output register; a sample is fetched one load
        // ahead so its bytes are ready the cycle after the previous sample's last byte.
        if (!tx_valid_q || tx_ready) begin
          if (cnt_q != CW'(TOTAL)) begin
            tx_valid_d = 1'b1;
            cnt_d      = cnt_q + CW'(1);
            if (cnt_q == CW'(0)) begin
              tx_data_d = HDR0;
              re        = 1'b1;
              rd_ptr_d  = rd_ptr_q + AW'(1);
            end else if (cnt_q == CW'(1)) begin
              tx_data_d = HDR1;
            end else begin
              tx_data_d = smp_byte;
              if (bsel_q == BSW'(BYTES - 1)) begin
                bsel_d = '0;
                if (cnt_q != CW'(TOTAL - 1)) begin
                  re       = 1'b1;
                  rd_ptr_d = rd_ptr_q + AW'(1);
                end
              end else begin
                bsel_d = bsel_q + BSW'(1);
              end
            end
          end else begin
            tx_valid_d = 1'b0;
            done_d     = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      trig_addr_q <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      bsel_q      <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_addr_q <= trig_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      bsel_q      <= bsel_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      done_q      <= done_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;

endmodule
